// File: rtl/ip_fifo_pkg.sv
// ip_fifo_pkg: default geometry shared by the FIFO top and its storage array.
package ip_fifo_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int ADDR_WIDTH  = 13;
    localparam int USEDW_WIDTH = ADDR_WIDTH + 1;

endpackage : ip_fifo_pkg

// File: rtl/ip_fifo_ram.sv
// ip_fifo_ram: simple dual-port storage, synchronous write, asynchronous read.
// Contents are never cleared; the FIFO top tracks validity with its pointers.
module ip_fifo_ram
    import ip_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = ip_fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = ip_fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead read: the addressed word is visible without a clock.
    assign rdata = mem[raddr];

endmodule : ip_fifo_ram

// File: rtl/ip_fifo.sv
// ip_fifo: single-clock show-ahead FIFO with read- and write-side status views.
// Optional feature: define IP_FIFO_WRFULL_EN to add the registered wrfull output.
module ip_fifo
    import ip_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = ip_fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = ip_fifo_pkg::ADDR_WIDTH,
    parameter int USEDW_WIDTH = ip_fifo_pkg::USEDW_WIDTH
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   wrreq,
    input  logic                   rdreq,
    output logic [DATA_WIDTH-1:0]  q,
    output logic                   rdempty,
    output logic [USEDW_WIDTH-1:0] rdusedw,
    output logic                   wrempty,
    output logic [USEDW_WIDTH-1:0] wrusedw
`ifdef IP_FIFO_WRFULL_EN
    ,
    output logic                   wrfull
`endif
);

    // Count value meaning "every slot occupied".
    localparam logic [USEDW_WIDTH-1:0] FULL_CNT = USEDW_WIDTH'(2 ** ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [USEDW_WIDTH-1:0] count;
    logic [USEDW_WIDTH-1:0] count_nxt;
    logic                   empty_r;
    logic                   wr_ok;
    logic                   rd_ok;

    // Decide which requests are honoured this cycle and the resulting fill level.
    always_comb begin
        wr_ok     = wrreq && (count != FULL_CNT);
        rd_ok     = rdreq && (count != '0);
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointers, count and empty flag; reset wins over any request on the same edge.
    always_ff @(posedge clk) begin
        if (aclr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_r <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_nxt;
            empty_r <= (count_nxt == '0);
        end
    end

`ifdef IP_FIFO_WRFULL_EN
    // Full flag registered alongside the count so it never lags it.
    always_ff @(posedge clk) begin
        if (aclr) begin
            wrfull <= 1'b0;
        end else begin
            wrfull <= (count_nxt == FULL_CNT);
        end
    end
`endif

    ip_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok && !aclr),
        .waddr (wr_ptr),
        .wdata (data),
        .raddr (rd_ptr),
        .rdata (q)
    );

    // Both clock-domain views are the same single-clock count.
    assign rdusedw = count;
    assign wrusedw = count;
    assign rdempty = empty_r;
    assign wrempty = empty_r;

endmodule : ip_fifo

// File: tb/tb_ip_fifo.sv
// tb_ip_fifo: directed scoreboard bench for ip_fifo (default 16 x 8192 geometry).
module tb_ip_fifo;

    localparam int DW    = 16;
    localparam int AW    = 13;
    localparam int UW    = 14;
    localparam int DEPTH = 8192;

    logic          clk = 1'b0;
    logic          aclr;
    logic [DW-1:0] data;
    logic          wrreq;
    logic          rdreq;
    logic [DW-1:0] q;
    logic          rdempty;
    logic [UW-1:0] rdusedw;
    logic          wrempty;
    logic [UW-1:0] wrusedw;
`ifdef IP_FIFO_WRFULL_EN
    logic          wrfull;
`endif

    ip_fifo #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .USEDW_WIDTH (UW)
    ) dut (
        .clk     (clk),
        .aclr    (aclr),
        .data    (data),
        .wrreq   (wrreq),
        .rdreq   (rdreq),
        .q       (q),
        .rdempty (rdempty),
        .rdusedw (rdusedw),
        .wrempty (wrempty),
        .wrusedw (wrusedw)
`ifdef IP_FIFO_WRFULL_EN
        ,
        .wrfull  (wrfull)
`endif
    );

    always #5 clk = ~clk;

    int      n_vec = 0;
    int      n_err = 0;
    logic [DW-1:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all status outputs against the scoreboard depth.
    task automatic chk_status(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".rdusedw"}, 32'(rdusedw), 32'(n));
        chk({tag, ".wrusedw"}, 32'(wrusedw), 32'(n));
        chk({tag, ".rdempty"}, 32'(rdempty), 32'(n == 0));
        chk({tag, ".wrempty"}, 32'(wrempty), 32'(n == 0));
`ifdef IP_FIFO_WRFULL_EN
        chk({tag, ".wrfull"}, 32'(wrfull), 32'(n == DEPTH));
`endif
    endtask

    // One clock: drive inputs, check the head word on an accepted read, advance model.
    task automatic step(input logic a, input logic w, input logic [DW-1:0] d, input logic r);
        logic wa;
        logic ra;
        aclr  = a;
        wrreq = w;
        data  = d;
        rdreq = r;
        wa = !a && w && (sb.size() < DEPTH);
        ra = !a && r && (sb.size() > 0);
        if (ra) begin
            chk("q_head", 32'(q), 32'(sb[0]));
        end
        @(posedge clk);
        #1;
        if (a) begin
            sb.delete();
        end else begin
            if (ra) void'(sb.pop_front());
            if (wa) sb.push_back(d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_i;
        int cyc;
        aclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = '0;

        // Reset then idle
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_status("reset_idle");

        // Single word is visible before any read
        step(0, 1, 16'hA5A5, 0);
        chk("a5_rdempty", 32'(rdempty), 32'd0);
        chk("a5_q", 32'(q), 32'h0000A5A5);
        step(0, 0, 0, 1);
        chk_status("a5_drained");

        // 100 back-to-back writes, then 100 reads
        for (int i = 0; i < 100; i++) step(0, 1, DW'(i), 0);
        chk_status("fill100");
        for (int i = 0; i < 100; i++) step(0, 0, 0, 1);
        chk_status("drain100");

        // Concurrent traffic with periodic read stalls
        wr_i = 0;
        cyc  = 0;
        while ((wr_i < 500 || sb.size() > 0) && cyc < 3000) begin
            step(0, wr_i < 500, DW'(1000 + wr_i), (cyc % 7) != 3);
            if (wr_i < 500) wr_i++;
            cyc++;
            chk("conc_usedw", 32'(rdusedw), 32'(sb.size()));
        end
        chk("conc_done", 32'(cyc < 3000), 32'd1);
        chk_status("conc_end");

        // Half-depth write and readback
        for (int i = 0; i < 4096; i++) step(0, 1, DW'(i) ^ 16'h5555, 0);
        chk_status("half");
        for (int i = 0; i < 4096; i++) step(0, 0, 0, 1);
        chk_status("half_drained");

        // Fill across the pointer wrap, then hold wrreq while full
        for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(i * 3), 0);
        chk_status("full");
        for (int i = 0; i < 4; i++) step(0, 1, 16'hDEAD, 0);
        chk_status("full_hold");
        chk("full_q", 32'(q), 32'd0);

        // Full with both requests: only the read is honoured
        step(0, 1, 16'hBEEF, 1);
        chk_status("full_both");
        chk("full_both_q", 32'(q), 32'd3);

        // Reset mid-transfer, with requests asserted
        step(1, 0, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 1, 16'hFFFF, 0);
        chk_status("ff50");
        step(1, 1, 16'hFFFF, 1);
        chk_status("aclr_pulse");
        step(0, 0, 0, 1);
        chk_status("rd_on_empty");

        // Empty with both requests: only the write is honoured
        step(0, 1, 16'h1234, 1);
        chk_status("empty_both");
        chk("empty_both_q", 32'(q), 32'h00001234);
        step(0, 0, 0, 1);
        chk_status("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ip_fifo
